// File: rtl/reg_bank_responder.sv
// User-side register bank for the host register-access link: control, status,
// cycle counter and configuration words, with single-cycle registered reads.
module reg_bank_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ADDR_WIDTH-1:0]              user_addr,
   input  logic                               user_wren,
   input  logic [DATA_WIDTH-1:0]              user_wdat,
   input  logic                               user_rden,
   output logic [DATA_WIDTH-1:0]              user_rdat,
   output logic                               user_rvld,
   output logic                               core_start,
   output logic                               core_soft_rst,
   output logic                               core_busy,
   input  logic                               core_done,
   output logic [DATA_WIDTH*(NUM_REGS-3)-1:0] cfg_regs
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

   logic [DATA_WIDTH-1:2] ctrl_r;
   logic                  busy_r;
   logic                  done_r;
   logic [DATA_WIDTH-1:0] cycles_r;
   logic [DATA_WIDTH-1:0] cfg_r [3:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] rdat_r;
   logic                  rvld_r;
   logic                  start_r;
   logic                  soft_rst_r;

   logic                  in_range_s;
   logic [IDX_W-1:0]      idx_s;
   logic                  wr_ctrl_s;
   logic                  wr_status_s;
   logic                  soft_rst_s;
   logic                  start_s;
   logic                  done_take_s;
   logic                  busy_nx_s;
   logic                  done_nx_s;
   logic [DATA_WIDTH-1:0] cycles_nx_s;
   logic [DATA_WIDTH-1:0] rd_mux_s;

   assign in_range_s  = (user_addr < ADDR_WIDTH'(NUM_REGS));
   assign idx_s       = user_addr[IDX_W-1:0];
   assign wr_ctrl_s   = user_wren & in_range_s & (idx_s == IDX_W'(0));
   assign wr_status_s = user_wren & in_range_s & (idx_s == IDX_W'(1));

   // Core handshake: soft reset beats everything, done beats a DONE clear.
   always_comb begin
      soft_rst_s  = wr_ctrl_s & user_wdat[1];
      start_s     = wr_ctrl_s & user_wdat[0] & ~user_wdat[1] & ~busy_r;
      done_take_s = core_done & busy_r;
      busy_nx_s   = busy_r;
      done_nx_s   = done_r;
      cycles_nx_s = cycles_r;
      if (soft_rst_s) begin
         busy_nx_s   = 1'b0;
         done_nx_s   = 1'b0;
         cycles_nx_s = {DATA_WIDTH{1'b0}};
      end else begin
         if (start_s) begin
            busy_nx_s   = 1'b1;
            cycles_nx_s = {DATA_WIDTH{1'b0}};
         end else if (busy_r) begin
            busy_nx_s = ~done_take_s;
            if (cycles_r != ALL_ONES) begin
               cycles_nx_s = cycles_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               cycles_nx_s = cycles_r;
            end
         end else begin
            busy_nx_s = busy_r;
         end
         if (done_take_s) begin
            done_nx_s = 1'b1;
         end else if (wr_status_s && user_wdat[1]) begin
            done_nx_s = 1'b0;
         end else begin
            done_nx_s = done_r;
         end
      end
   end

   // Read data selection from the current (pre-write) register contents.
   always_comb begin
      rd_mux_s = {DATA_WIDTH{1'b0}};
      if (!in_range_s) begin
         rd_mux_s = {DATA_WIDTH{1'b0}};
      end else begin
         case (idx_s)
            IDX_W'(0): rd_mux_s = {ctrl_r, 2'b00};
            IDX_W'(1): rd_mux_s = {{(DATA_WIDTH-2){1'b0}}, done_r, busy_r};
            IDX_W'(2): rd_mux_s = cycles_r;
            default:   rd_mux_s = cfg_r[idx_s];
         endcase
      end
   end

   // Register state, read response and one-cycle core pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_r     <= {(DATA_WIDTH-2){1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         cycles_r   <= {DATA_WIDTH{1'b0}};
         rdat_r     <= {DATA_WIDTH{1'b0}};
         rvld_r     <= 1'b0;
         start_r    <= 1'b0;
         soft_rst_r <= 1'b0;
         for (int g = 3; g < NUM_REGS; g++) begin
            cfg_r[g] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         busy_r     <= busy_nx_s;
         done_r     <= done_nx_s;
         cycles_r   <= cycles_nx_s;
         start_r    <= start_s;
         soft_rst_r <= soft_rst_s;
         rvld_r     <= user_rden;
         if (user_rden) begin
            rdat_r <= rd_mux_s;
         end
         if (wr_ctrl_s) begin
            ctrl_r <= user_wdat[DATA_WIDTH-1:2];
         end
         for (int g = 3; g < NUM_REGS; g++) begin
            if (user_wren && in_range_s && (idx_s == IDX_W'(g))) begin
               cfg_r[g] <= user_wdat;
            end
         end
      end
   end

   for (genvar g = 3; g < NUM_REGS; g++) begin : g_cfg_flat
      assign cfg_regs[(g-3)*DATA_WIDTH +: DATA_WIDTH] = cfg_r[g];
   end

   assign user_rdat     = rdat_r;
   assign user_rvld     = rvld_r;
   assign core_start    = start_r;
   assign core_soft_rst = soft_rst_r;
   assign core_busy     = busy_r;

endmodule

// File: doc/reg_bank_responder.md
Name: reg_bank_responder

Overview:
- User-side endpoint of the host register-access link.
- Accepts the user_addr / user_wren / user_wdat / user_rden strobes produced by the PS-side generator.
- Holds the accelerator's control, status, cycle-count and configuration registers, and returns read data with user_rvld.
- Sits between the PS register-access generator and the accelerator core: start/soft-reset pulses and config values go to the core; busy/done status comes back from it.

Parameters:
- DATA_WIDTH, 32, register and data-bus width.
- ADDR_WIDTH, 32, user_addr width; the full address is compared.
- NUM_REGS, 16, number of word registers decoded (minimum 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- user_addr  input  ADDR_WIDTH  register index (word address).
- user_wren  input  1  write strobe, one cycle.
- user_wdat  input  DATA_WIDTH  write data.
- user_rden  input  1  read strobe, one cycle.
- user_rdat  output  DATA_WIDTH  read data, valid while user_rvld is high.
- user_rvld  output  1  read-data-valid pulse.
- core_start  output  1  one-cycle start pulse to the core.
- core_soft_rst  output  1  one-cycle soft-reset pulse to the core.
- core_busy  output  1  core-running flag (mirrors STATUS[0]).
- core_done  input  1  core completion pulse.
- cfg_regs  output  DATA_WIDTH*(NUM_REGS-3)  flattened config registers; index 3 occupies the LSBs.

Behaviour:
- Register map (word index):
  - 0 CTRL: bit0 START (W1, self-clearing); bit1 SOFT_RST (W1, self-clearing); bits[DATA_WIDTH-1:2] are stored RW. Reads return stored bits with bits0 and 1 as 0.
  - 1 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); other bits read 0.
  - 2 CYCLES: RO; writes ignored.
  - 3..NUM_REGS-1 CFG: RW, driven continuously on cfg_regs.
- Addresses >= NUM_REGS: writes ignored; reads return 0 with user_rvld still asserted.
- Write: committed at the clk edge where user_wren=1. It is visible on cfg_regs and in reads from the next cycle.
- Read: user_rdat is registered on the edge where user_rden=1. user_rvld pulses high for exactly the following cycle; latency is 1.
  - Back-to-back reads give back-to-back rvld pulses.
  - user_rdat holds its last value when rvld=0.
- wren and rden asserted in the same cycle (normal on an address change):
  - Both are serviced.
  - The read returns the pre-write contents.
  - The write commits on the same edge.
- START:
  - Writing bit0=1 while BUSY=0 makes core_start=1 for the cycle after the write edge, with BUSY=1 and CYCLES=0 in that same cycle.
  - Writing bit0=1 while BUSY=1 is ignored: no pulse, no counter clear.
- SOFT_RST:
  - Writing bit1=1 makes core_soft_rst=1 for one cycle and clears BUSY, DONE and CYCLES on the same edge.
  - Pending START in the same write is ignored; SOFT_RST wins.
- core_done:
  - Sampled only while BUSY=1. It clears BUSY and sets DONE on the next edge.
  - Ignored while BUSY=0.
  - If it arrives in the same cycle as a START write while BUSY=1, done is taken and the start is ignored.
- DONE W1C:
  - A STATUS write with bit1=1 clears DONE.
  - If the W1C write and core_done arrive in the same cycle, set wins and DONE=1.
- CYCLES:
  - Increments by 1 every cycle BUSY=1 and saturates at all-ones; no wrap.
  - Holds its value after done until the next accepted START or a SOFT_RST.
- Reset (async assert; deassert used synchronously with clk), all values 0:
  - user_rdat, user_rvld, core_start, core_soft_rst, core_busy.
  - All registers, including cfg_regs.
  - Reset mid-transaction drops any pending rvld.
- No other internal state; no back-pressure (the responder always accepts strobes).

Test Plan:
1. After reset, read idx 0..15 individually: each returns 0 with user_rvld exactly 1 cycle after rden. Read idx 20 gives rdat=0 and rvld=1.
2. Write 0xA5A5_0003 to idx 5, then read idx 5: rdat=0xA5A5_0003. cfg_regs[95:64]=0xA5A5_0003 one cycle after the write. Write 0x1234 to idx 2, then read: still the current CYCLES value.
3. Simultaneous wren and rden to idx 7 (old value 0x11, new 0x22): rdat=0x11. The next read gives 0x22.
4. Write CTRL=0x1: core_start high for 1 cycle, BUSY=1. Hold 10 cycles, pulse core_done: STATUS reads 0x2 and CYCLES reads 11. A second START while busy gives no pulse.
5. Assert core_done in the same cycle as a STATUS write of 0x2: DONE stays 1. A later 0x2 write alone clears DONE to 0.
6. Mid-run, write CTRL=0x3: core_soft_rst pulses for 1 cycle, core_start stays 0, and STATUS=CYCLES=0. Separately, assert rst mid-read: rvld stays 0 and cfg_regs=0.
